// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared types and constants for the instruction-fetch queue.
//                Holds the fetch FSM state encoding, the Sysbus tag fields
//                used for line reads, and the line/beat geometry.
//  Revision    : 1.0  initial release
// ============================================================================
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    RECV  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_t;

  // Sysbus request tag fields: {READ, MEMORY, 8'b0}
  localparam logic       READ   = 1'b1;
  localparam logic [3:0] MEMORY = 4'b0001;

  localparam int LINE_BYTES     = 64;
  localparam int BEATS_PER_LINE = 8;
  localparam int BEAT_CNT_W     = $clog2(BEATS_PER_LINE);

endpackage
`default_nettype wire

// File: rtl/fetch_queue_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_queue_if
//  Description : Sysbus request/response channel between the fetch queue
//                (master) and the memory side (slave).
//                reqcyc/req/reqtag/reqack : line read request handshake
//                respcyc/resp/respack     : 64-bit response beats
//  Revision    : 1.0  initial release
// ============================================================================
interface fetch_queue_if #(
  parameter int TAG_BITS  = 13,
  parameter int BEAT_BITS = 64
);
  logic                 reqcyc;
  logic [63:0]          req;
  logic [TAG_BITS-1:0]  reqtag;
  logic                 reqack;
  logic                 respcyc;
  logic [BEAT_BITS-1:0] resp;
  logic                 respack;

  modport master (
    output reqcyc, req, reqtag, respack,
    input  reqack, respcyc, resp
  );

  modport slave (
    input  reqcyc, req, reqtag, respack,
    output reqack, respcyc, resp
  );
endinterface
`default_nettype wire

// File: rtl/fetch_byte_ring.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_byte_ring
//  Description : Circular byte buffer with an 8-byte aligned write port and
//                a rotated WINDOW_BYTES read port starting at rd_ptr.
//                Ports: clk, reset (async, active low), reset_rd_off (rd_ptr
//                value under reset), flush/flush_rd_off (restart pointers),
//                wr_en/wr_data (one beat at wr_ptr), consume (rd_ptr step),
//                win_bytes/win_avail (decoder window), used_bytes (space
//                held from the beat-aligned read point up to wr_ptr).
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_byte_ring #(
  parameter int BUF_BYTES    = 128,
  parameter int BEAT_BITS    = 64,
  parameter int WINDOW_BYTES = 15
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [2:0]                  reset_rd_off,
  input  logic                        flush,
  input  logic [2:0]                  flush_rd_off,
  input  logic                        wr_en,
  input  logic [BEAT_BITS-1:0]        wr_data,
  input  logic [3:0]                  consume,
  output logic [WINDOW_BYTES*8-1:0]   win_bytes,
  output logic [3:0]                  win_avail,
  output logic [$clog2(BUF_BYTES):0]  used_bytes
);
  import fetch_pkg::*;

  localparam int IDX_W      = $clog2(BUF_BYTES);
  localparam int PTR_W      = IDX_W + 1;
  localparam int BEAT_BYTES = BEAT_BITS / 8;
  // Storage plus a copy of the first WINDOW_BYTES bytes past the end, so
  // the window read never has to wrap.
  localparam int MEM_DEPTH  = BUF_BYTES + WINDOW_BYTES;
  localparam int MEM_AW     = $clog2(MEM_DEPTH);

  generate
    if (WINDOW_BYTES > 15) begin : g_bad_window
      $error("WINDOW_BYTES must be 15 or less");
    end
    if ((BUF_BYTES & (BUF_BYTES - 1)) != 0) begin : g_bad_buf
      $error("BUF_BYTES must be a power of 2");
    end
  endgenerate

  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [7:0]        r_mem [MEM_DEPTH];
  logic [PTR_W-1:0]  w_diff;
  logic [PTR_W-1:0]  w_occ;
  logic [MEM_AW-1:0] w_wr_base;
  logic [MEM_AW-1:0] w_rd_base;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= PTR_W'(reset_rd_off);
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= PTR_W'(flush_rd_off);
    end else begin
      if (wr_en)
        r_wr_ptr <= r_wr_ptr + PTR_W'(BEAT_BYTES);
      r_rd_ptr <= r_rd_ptr + PTR_W'(consume);
    end
  end

  // After a restart rd_ptr may sit up to 7 bytes ahead of wr_ptr until the
  // first kept beat lands; that shows up as a huge modulo difference and
  // means "nothing readable yet".
  assign w_diff     = r_wr_ptr - r_rd_ptr;
  assign w_occ      = (w_diff > PTR_W'(BUF_BYTES)) ? '0 : w_diff;
  assign win_avail  = (w_occ > PTR_W'(WINDOW_BYTES)) ? 4'(WINDOW_BYTES) : w_occ[3:0];
  // Space is accounted from the beat containing rd_ptr, since the bytes in
  // front of rd_ptr within that beat still occupy their slots.
  assign used_bytes = r_wr_ptr - {r_rd_ptr[PTR_W-1:3], 3'b000};

  assign w_wr_base  = MEM_AW'(r_wr_ptr[IDX_W-1:0]);
  assign w_rd_base  = MEM_AW'(r_rd_ptr[IDX_W-1:0]);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int k = 0; k < BEAT_BYTES; k++) begin
        r_mem[w_wr_base + MEM_AW'(k)] <= wr_data[8*k +: 8];
        if (w_wr_base + MEM_AW'(k) < MEM_AW'(WINDOW_BYTES))
          r_mem[w_wr_base + MEM_AW'(k) + MEM_AW'(BUF_BYTES)] <= wr_data[8*k +: 8];
      end
    end
  end

  always_comb begin
    win_bytes = '0;
    for (int i = 0; i < WINDOW_BYTES; i++)
      win_bytes[8*i +: 8] = r_mem[w_rd_base + MEM_AW'(i)];
  end

endmodule
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_queue
//  Description : Instruction-fetch front end. Issues line reads from the
//                fetch RIP over Sysbus, stores returned beats in a byte ring
//                and presents a byte window to the decoder. A redirect
//                flushes the queue and restarts at a new RIP.
//                Ports: clk, reset (async, active low), entry (start RIP),
//                bus (Sysbus master), win_bytes/win_avail/win_rip (window),
//                consume (bytes retired), redirect_valid/redirect_rip.
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_queue #(
  parameter int BUF_BYTES    = 128,
  parameter int LINE_BYTES   = 64,
  parameter int BEAT_BITS    = 64,
  parameter int WINDOW_BYTES = 15,
  parameter int TAG_BITS     = 13
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [63:0]               entry,
  fetch_queue_if.master             bus,
  output logic [WINDOW_BYTES*8-1:0] win_bytes,
  output logic [3:0]                win_avail,
  output logic [63:0]               win_rip,
  input  logic [3:0]                consume,
  input  logic                      redirect_valid,
  input  logic [63:0]               redirect_rip
);
  import fetch_pkg::*;

  generate
    if (LINE_BYTES != BEATS_PER_LINE * BEAT_BITS / 8) begin : g_bad_line
      $error("LINE_BYTES must be exactly 8 beats");
    end
  endgenerate

  localparam logic [63:0] LINE_MASK = ~(64'(LINE_BYTES) - 64'd1);

  fetch_state_t            r_state, w_state_next;
  logic [63:0]             r_line, w_line_next;   // next line to request
  logic [63:0]             r_req, w_req_next;     // address on the bus
  logic [2:0]              r_skip, w_skip_next;   // leading beats to drop
  logic [BEAT_CNT_W-1:0]   r_beat_cnt, w_beat_next;
  logic                    r_drain_pend, w_drain_pend_next;
  logic [63:0]             r_win_rip;
  logic                    w_wr_en;
  logic                    w_last_beat;
  logic                    w_space_ok;
  logic [$clog2(BUF_BYTES):0] w_used;

  assign bus.reqcyc  = (r_state == REQ);
  assign bus.req     = r_req;
  assign bus.reqtag  = TAG_BITS'({READ, MEMORY, 8'h00});
  assign bus.respack = bus.respcyc;
  assign win_rip     = r_win_rip;

  assign w_last_beat = bus.respcyc && (r_beat_cnt == BEAT_CNT_W'(BEATS_PER_LINE - 1));
  assign w_space_ok  = (int'(w_used) + LINE_BYTES) <= BUF_BYTES;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_line       <= entry & LINE_MASK;
      r_req        <= entry & LINE_MASK;
      r_skip       <= entry[5:3];
      r_beat_cnt   <= '0;
      r_drain_pend <= 1'b0;
      r_win_rip    <= entry;
    end else begin
      r_state      <= w_state_next;
      r_line       <= w_line_next;
      r_req        <= w_req_next;
      r_skip       <= w_skip_next;
      r_beat_cnt   <= w_beat_next;
      r_drain_pend <= w_drain_pend_next;
      r_win_rip    <= redirect_valid ? redirect_rip : r_win_rip + 64'(consume);
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_line_next       = r_line;
    w_req_next        = r_req;
    w_skip_next       = r_skip;
    w_beat_next       = r_beat_cnt;
    w_drain_pend_next = r_drain_pend;
    w_wr_en           = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (!redirect_valid && w_space_ok) begin
          w_state_next = REQ;
          w_req_next   = r_line;
        end
      end
      REQ: begin
        // A request already on the bus is never withdrawn; a redirect here
        // only turns the coming line into one to be drained.
        if (bus.reqack) begin
          w_state_next      = (r_drain_pend || redirect_valid) ? DRAIN : RECV;
          w_beat_next       = '0;
          w_drain_pend_next = 1'b0;
        end else if (redirect_valid) begin
          w_drain_pend_next = 1'b1;
        end
      end
      RECV: begin
        if (bus.respcyc) begin
          w_beat_next = r_beat_cnt + 1'b1;
          w_wr_en     = !redirect_valid && (r_beat_cnt >= r_skip);
        end
        if (w_last_beat) begin
          w_state_next = IDLE;
          if (!redirect_valid) begin
            w_skip_next = '0;
            w_line_next = r_line + 64'(LINE_BYTES);
          end
        end else if (redirect_valid) begin
          w_state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (bus.respcyc)
          w_beat_next = r_beat_cnt + 1'b1;
        if (w_last_beat)
          w_state_next = IDLE;
      end
    endcase

    if (redirect_valid) begin
      w_line_next = redirect_rip & LINE_MASK;
      w_skip_next = redirect_rip[5:3];
    end
  end

  fetch_byte_ring #(
    .BUF_BYTES    (BUF_BYTES),
    .BEAT_BITS    (BEAT_BITS),
    .WINDOW_BYTES (WINDOW_BYTES)
  ) u_ring (
    .clk          (clk),
    .reset        (reset),
    .reset_rd_off (entry[2:0]),
    .flush        (redirect_valid),
    .flush_rd_off (redirect_rip[2:0]),
    .wr_en        (w_wr_en),
    .wr_data      (bus.resp),
    .consume      (consume),
    .win_bytes    (win_bytes),
    .win_avail    (win_avail),
    .used_bytes   (w_used)
  );

  a_consume_in_window: assert property (
    @(posedge clk) disable iff (!reset) consume <= win_avail
  ) else $fatal(1, "consume exceeds win_avail");

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_queue
//  Description : Directed self-checking bench for fetch_queue. Memory bytes
//                are modelled as the low byte of their address, so every
//                window byte i is expected to equal (win_rip + i)[7:0].
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fetch_queue;
  localparam int WIN = 15;

  logic              clk = 1'b0;
  logic              reset;
  logic [63:0]       entry;
  logic [WIN*8-1:0]  win_bytes;
  logic [3:0]        win_avail;
  logic [63:0]       win_rip;
  logic [3:0]        consume;
  logic              redirect_valid;
  logic [63:0]       redirect_rip;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  fetch_queue_if #(.TAG_BITS(13), .BEAT_BITS(64)) bus ();

  fetch_queue #(
    .BUF_BYTES(128), .LINE_BYTES(64), .BEAT_BITS(64), .WINDOW_BYTES(WIN), .TAG_BITS(13)
  ) dut (
    .clk(clk), .reset(reset), .entry(entry), .bus(bus),
    .win_bytes(win_bytes), .win_avail(win_avail), .win_rip(win_rip),
    .consume(consume), .redirect_valid(redirect_valid), .redirect_rip(redirect_rip)
  );

  function automatic logic [63:0] beat_data(input logic [63:0] line, input int b);
    logic [63:0] d, a;
    d = '0;
    for (int k = 0; k < 8; k++) begin
      a = line + 64'(8 * b + k);
      d[8*k +: 8] = a[7:0];
    end
    return d;
  endfunction

  function automatic logic [WIN*8-1:0] win_model(input logic [63:0] rip);
    logic [WIN*8-1:0] w;
    logic [63:0] a;
    for (int i = 0; i < WIN; i++) begin
      a = rip + 64'(i);
      w[8*i +: 8] = a[7:0];
    end
    return w;
  endfunction

  function automatic logic [WIN*8-1:0] win_mask(input int avail);
    logic [WIN*8-1:0] m;
    m = '0;
    for (int i = 0; i < WIN; i++)
      if (i < avail) m[8*i +: 8] = 8'hFF;
    return m;
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input logic [63:0] e);
    reset = 1'b0; entry = e;
    bus.reqack = 1'b0; bus.respcyc = 1'b0; bus.resp = '0;
    consume = '0; redirect_valid = 1'b0; redirect_rip = '0;
    repeat (3) cycle();
    reset = 1'b1;
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (bus.reqcyc) ok = 1'b1;
      else cycle();
    end
  endtask

  task automatic ack_now();
    bus.reqack = 1'b1;
    cycle();
    bus.reqack = 1'b0;
  endtask

  task automatic send_beat(input logic [63:0] line, input int b);
    bus.respcyc = 1'b1;
    bus.resp    = beat_data(line, b);
    cycle();
    bus.respcyc = 1'b0;
  endtask

  // ---------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b0; entry = 64'h1000;
    bus.reqack = 1'b0; bus.respcyc = 1'b0; bus.resp = '0;
    consume = '0; redirect_valid = 1'b0; redirect_rip = '0;
    repeat (3) cycle();
    n_checks++;
    if (bus.reqcyc !== 1'b0 || bus.req !== 64'h1000)
      $display("FAIL reset_req: reqcyc=%b req=%h want 0 / 1000", bus.reqcyc, bus.req);
    else n_pass++;
    n_checks++;
    if (win_avail !== 4'd0 || win_rip !== 64'h1000)
      $display("FAIL reset_win: avail=%0d rip=%h want 0 / 1000", win_avail, win_rip);
    else n_pass++;
    n_checks++;
    if (bus.reqtag !== 13'h1100)
      $display("FAIL reqtag: got %h want 1100", bus.reqtag);
    else n_pass++;
    bus.respcyc = 1'b1;
    #1;
    n_checks++;
    if (bus.respack !== 1'b1)
      $display("FAIL respack_in_reset: got %b want 1", bus.respack);
    else n_pass++;
    bus.respcyc = 1'b0;
    reset = 1'b1;
    cycle();
    n_checks++;
    if (bus.reqcyc !== 1'b1)
      $display("FAIL first_req_latency: reqcyc=%b want 1", bus.reqcyc);
    else n_pass++;
  endtask

  task automatic test_aligned();
    bit ok;
    bit held = 1'b1;
    apply_reset(64'h1000);
    wait_req(ok);
    n_checks++;
    if (!ok || bus.req !== 64'h1000)
      $display("FAIL aligned_req: ok=%b req=%h want 1000", ok, bus.req);
    else n_pass++;
    for (int i = 0; i < 2; i++) begin
      cycle();
      if (bus.reqcyc !== 1'b1 || bus.req !== 64'h1000) held = 1'b0;
    end
    n_checks++;
    if (!held) $display("FAIL aligned_hold: reqcyc=%b req=%h want 1 / 1000", bus.reqcyc, bus.req);
    else n_pass++;
    ack_now();
    n_checks++;
    if (bus.reqcyc !== 1'b0) $display("FAIL aligned_ack_drop: reqcyc=%b want 0", bus.reqcyc);
    else n_pass++;
    send_beat(64'h1000, 0);
    n_checks++;
    if (win_avail !== 4'd8) $display("FAIL aligned_avail8: got %0d want 8", win_avail);
    else n_pass++;
    send_beat(64'h1000, 1);
    n_checks++;
    if (win_avail !== 4'd15 || win_rip !== 64'h1000 || win_bytes[7:0] !== 8'h00)
      $display("FAIL aligned_avail15: avail=%0d rip=%h b0=%h want 15 / 1000 / 00",
               win_avail, win_rip, win_bytes[7:0]);
    else n_pass++;
    n_checks++;
    if (win_bytes !== win_model(64'h1000))
      $display("FAIL aligned_window: got %h want %h", win_bytes, win_model(64'h1000));
    else n_pass++;
    for (int b = 2; b < 8; b++) send_beat(64'h1000, b);
    wait_req(ok);
    n_checks++;
    if (!ok || bus.req !== 64'h1040)
      $display("FAIL aligned_next_req: ok=%b req=%h want 1040", ok, bus.req);
    else n_pass++;
  endtask

  task automatic test_unaligned();
    bit ok;
    apply_reset(64'h1013);
    wait_req(ok);
    n_checks++;
    if (!ok || bus.req !== 64'h1000)
      $display("FAIL unaligned_req: ok=%b req=%h want 1000", ok, bus.req);
    else n_pass++;
    ack_now();
    send_beat(64'h1000, 0);
    send_beat(64'h1000, 1);
    n_checks++;
    if (win_avail !== 4'd0) $display("FAIL unaligned_skip: avail=%0d want 0", win_avail);
    else n_pass++;
    send_beat(64'h1000, 2);
    n_checks++;
    if (win_avail !== 4'd5 || win_rip !== 64'h1013 || win_bytes[7:0] !== 8'h13)
      $display("FAIL unaligned_first: avail=%0d rip=%h b0=%h want 5 / 1013 / 13",
               win_avail, win_rip, win_bytes[7:0]);
    else n_pass++;
    n_checks++;
    if (((win_bytes ^ win_model(64'h1013)) & win_mask(5)) !== '0)
      $display("FAIL unaligned_window: got %h want %h", win_bytes, win_model(64'h1013));
    else n_pass++;
    for (int b = 3; b < 8; b++) send_beat(64'h1000, b);
    wait_req(ok);
    n_checks++;
    if (!ok || bus.req !== 64'h1040)
      $display("FAIL unaligned_next_req: ok=%b req=%h want 1040", ok, bus.req);
    else n_pass++;
  endtask

  task automatic test_full_wrap();
    bit ok;
    bit quiet = 1'b1;
    bit win_ok = 1'b1;
    logic [63:0] rip;
    apply_reset(64'h0);
    wait_req(ok);
    ack_now();
    for (int b = 0; b < 8; b++) send_beat(64'h0, b);
    wait_req(ok);
    n_checks++;
    if (!ok || bus.req !== 64'h40)
      $display("FAIL full_second_req: ok=%b req=%h want 40", ok, bus.req);
    else n_pass++;
    ack_now();
    for (int b = 0; b < 8; b++) send_beat(64'h40, b);
    for (int i = 0; i < 10; i++) begin
      if (bus.reqcyc !== 1'b0) quiet = 1'b0;
      cycle();
    end
    n_checks++;
    if (!quiet || win_avail !== 4'd15)
      $display("FAIL full_no_third_req: quiet=%b avail=%0d want 1 / 15", quiet, win_avail);
    else n_pass++;
    rip = 64'h0;
    for (int j = 0; j < 5; j++) begin
      consume = 4'd15;
      cycle();
      consume = 4'd0;
      rip = rip + 64'd15;
      if (win_rip !== rip || win_avail !== 4'd15 || win_bytes !== win_model(rip)) win_ok = 1'b0;
      if (j == 3) begin
        n_checks++;
        if (bus.reqcyc !== 1'b0) $display("FAIL full_early_req: reqcyc=%b want 0 at rd=60", bus.reqcyc);
        else n_pass++;
      end
    end
    n_checks++;
    if (!win_ok) $display("FAIL full_consume_window: rip=%h got %h want %h", win_rip, win_bytes, win_model(rip));
    else n_pass++;
    wait_req(ok);
    n_checks++;
    if (!ok || bus.req !== 64'h80)
      $display("FAIL full_third_req: ok=%b req=%h want 80", ok, bus.req);
    else n_pass++;
    ack_now();
    for (int b = 0; b < 8; b++) send_beat(64'h80, b);
    win_ok = 1'b1;
    for (int j = 0; j < 3; j++) begin
      consume = 4'd15;
      cycle();
      consume = 4'd0;
      rip = rip + 64'd15;
      if (win_rip !== rip || win_avail !== 4'd15 || win_bytes !== win_model(rip)) win_ok = 1'b0;
    end
    n_checks++;
    if (!win_ok || rip !== 64'd120)
      $display("FAIL wrap_window: rip=%h got %h want %h", win_rip, win_bytes, win_model(rip));
    else n_pass++;
  endtask

  task automatic test_redirect_recv();
    bit ok;
    bit zero = 1'b1;
    apply_reset(64'h1000);
    wait_req(ok);
    ack_now();
    for (int b = 0; b < 4; b++) send_beat(64'h1000, b);
    redirect_valid = 1'b1; redirect_rip = 64'h2005;
    cycle();
    redirect_valid = 1'b0;
    n_checks++;
    if (win_avail !== 4'd0 || win_rip !== 64'h2005)
      $display("FAIL redir_recv_flush: avail=%0d rip=%h want 0 / 2005", win_avail, win_rip);
    else n_pass++;
    for (int b = 4; b < 8; b++) begin
      send_beat(64'h1000, b);
      if (win_avail !== 4'd0) zero = 1'b0;
    end
    n_checks++;
    if (!zero) $display("FAIL redir_recv_drop: avail=%0d want 0", win_avail);
    else n_pass++;
    wait_req(ok);
    n_checks++;
    if (!ok || bus.req !== 64'h2000)
      $display("FAIL redir_recv_req: ok=%b req=%h want 2000", ok, bus.req);
    else n_pass++;
    ack_now();
    send_beat(64'h2000, 0);
    n_checks++;
    if (win_avail !== 4'd3 || win_rip !== 64'h2005 || win_bytes[23:0] !== 24'h070605)
      $display("FAIL redir_recv_window: avail=%0d rip=%h b=%h want 3 / 2005 / 070605",
               win_avail, win_rip, win_bytes[23:0]);
    else n_pass++;
  endtask

  task automatic test_redirect_req();
    bit ok;
    bit zero = 1'b1;
    apply_reset(64'h1000);
    wait_req(ok);
    redirect_valid = 1'b1; redirect_rip = 64'h3008;
    cycle();
    redirect_valid = 1'b0;
    n_checks++;
    if (bus.reqcyc !== 1'b1 || bus.req !== 64'h1000 || win_rip !== 64'h3008)
      $display("FAIL redir_req_hold: reqcyc=%b req=%h rip=%h want 1 / 1000 / 3008",
               bus.reqcyc, bus.req, win_rip);
    else n_pass++;
    cycle();
    n_checks++;
    if (bus.reqcyc !== 1'b1 || bus.req !== 64'h1000)
      $display("FAIL redir_req_hold2: reqcyc=%b req=%h want 1 / 1000", bus.reqcyc, bus.req);
    else n_pass++;
    ack_now();
    for (int b = 0; b < 8; b++) begin
      send_beat(64'h1000, b);
      if (win_avail !== 4'd0 || bus.reqcyc !== 1'b0) zero = 1'b0;
    end
    n_checks++;
    if (!zero) $display("FAIL redir_req_drain: avail=%0d reqcyc=%b want 0 / 0", win_avail, bus.reqcyc);
    else n_pass++;
    wait_req(ok);
    n_checks++;
    if (!ok || bus.req !== 64'h3000)
      $display("FAIL redir_req_new: ok=%b req=%h want 3000", ok, bus.req);
    else n_pass++;
    ack_now();
    send_beat(64'h3000, 0);
    send_beat(64'h3000, 1);
    n_checks++;
    if (win_avail !== 4'd8 || win_bytes[7:0] !== 8'h08 || win_rip !== 64'h3008)
      $display("FAIL redir_req_window: avail=%0d b0=%h rip=%h want 8 / 08 / 3008",
               win_avail, win_bytes[7:0], win_rip);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    bit ok;
    apply_reset(64'h1000);
    wait_req(ok);
    ack_now();
    send_beat(64'h1000, 0);
    send_beat(64'h1000, 1);
    n_checks++;
    if (win_avail !== 4'd15) $display("FAIL areset_pre: avail=%0d want 15", win_avail);
    else n_pass++;
    bus.respcyc = 1'b1;
    bus.resp    = beat_data(64'h1000, 2);
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (win_avail !== 4'd0 || bus.reqcyc !== 1'b0 || bus.respack !== 1'b1)
      $display("FAIL areset_immediate: avail=%0d reqcyc=%b respack=%b want 0 / 0 / 1",
               win_avail, bus.reqcyc, bus.respack);
    else n_pass++;
    entry = 64'h4028;
    repeat (3) cycle();
    bus.respcyc = 1'b0;
    reset = 1'b1;
    n_checks++;
    if (win_avail !== 4'd0 || win_rip !== 64'h4028)
      $display("FAIL areset_held: avail=%0d rip=%h want 0 / 4028", win_avail, win_rip);
    else n_pass++;
    wait_req(ok);
    n_checks++;
    if (!ok || bus.req !== 64'h4000)
      $display("FAIL areset_restart_req: ok=%b req=%h want 4000", ok, bus.req);
    else n_pass++;
    ack_now();
    for (int b = 0; b < 5; b++) send_beat(64'h4000, b);
    send_beat(64'h4000, 5);
    n_checks++;
    if (win_avail !== 4'd8 || win_bytes[7:0] !== 8'h28)
      $display("FAIL areset_restart_window: avail=%0d b0=%h want 8 / 28", win_avail, win_bytes[7:0]);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_aligned();
    test_unaligned();
    test_full_wrap();
    test_redirect_recv();
    test_redirect_req();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", n_pass, n_checks);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
